// File: rtl/ahbl_sram_slave_if.sv
// rtl/ahbl_sram_slave_if.sv - AHB-Lite bus bundle between a master and the SRAM responder
interface ahbl_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahbl_sram_slave.sv
// rtl/ahbl_sram_slave.sv - AHB-Lite SRAM responder with byte lanes and two-cycle ERROR
// Wait-state insertion is built only when AHBL_SLV_WAIT_EN is defined.
module ahbl_sram_slave #(
  parameter int AW   = 10,
  parameter int WAIT = 1
) (
  input  logic HCLK,
  input  logic HRESETn,
  ahbl_sram_slave_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
`ifdef AHBL_SLV_WAIT_EN
    WAIT_ST,
`endif
    DATA,
    ERR1,
    ERR2
  } state_t;

  state_t        state;
  logic [AW-1:0] word_r;
  logic [1:0]    lo_r;
  logic [2:0]    size_r;
  logic          write_r;
  logic          hreadyout_r;
  logic          hresp_r;
  logic [3:0]    be;
  logic          accept;
  logic          illegal;
  logic          rd_phase;
  logic          unused_bits;

  logic [31:0] mem [0:(1<<AW)-1];

  if (WAIT > 7) begin : g_wait_out_of_range
  end

`ifdef AHBL_SLV_WAIT_EN
  localparam logic [2:0] WAIT_LD = 3'(WAIT);
  logic [2:0] wait_cnt;
`endif

  assign unused_bits = ^{bus.HADDR[31:AW+2], bus.HTRANS[0]};

  assign accept  = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign illegal = (bus.HSIZE > 3'd2)
                 | ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'b00))
                 | ((bus.HSIZE == 3'd1) & bus.HADDR[0]);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= IDLE;
      word_r      <= '0;
      lo_r        <= '0;
      size_r      <= '0;
      write_r     <= 1'b0;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
`ifdef AHBL_SLV_WAIT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
`ifdef AHBL_SLV_WAIT_EN
        WAIT_ST: begin
          if (wait_cnt <= 3'd1) begin
            wait_cnt    <= '0;
            state       <= DATA;
            hreadyout_r <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
`endif
        ERR1: begin
          state       <= ERR2;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all end with HREADYOUT high, so each may take a new address phase.
          if (accept) begin
            word_r  <= bus.HADDR[AW+1:2];
            lo_r    <= bus.HADDR[1:0];
            size_r  <= bus.HSIZE;
            write_r <= bus.HWRITE;
            if (illegal) begin
              state       <= ERR1;
              hreadyout_r <= 1'b0;
              hresp_r     <= 1'b1;
            end else begin
              hresp_r <= 1'b0;
`ifdef AHBL_SLV_WAIT_EN
              if (WAIT_LD != 3'd0) begin
                state       <= WAIT_ST;
                wait_cnt    <= WAIT_LD;
                hreadyout_r <= 1'b0;
              end else begin
                state       <= DATA;
                hreadyout_r <= 1'b1;
              end
`else
              state       <= DATA;
              hreadyout_r <= 1'b1;
`endif
            end
          end else begin
            state       <= IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    be = 4'b1111;
    case (size_r)
      3'd0:    be = 4'b0001 << lo_r;
      3'd1:    be = lo_r[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Commit is gated by the async-reset state, so a reset mid data phase drops the write.
  always_ff @(posedge HCLK) begin
    if (state == DATA && write_r) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_r][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

`ifdef AHBL_SLV_WAIT_EN
  assign rd_phase = ((state == DATA) || (state == WAIT_ST)) && !write_r;
`else
  assign rd_phase = (state == DATA) && !write_r;
`endif

  assign bus.HRDATA    = rd_phase ? mem[word_r] : 32'h0;
  assign bus.HREADYOUT = hreadyout_r;
  assign bus.HRESP     = hresp_r;

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// tb/tb_ahbl_sram_slave.sv - directed self-checking bench for ahbl_sram_slave
module tb_ahbl_sram_slave;

`ifdef AHBL_SLV_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int   total = 0;
  int   bad = 0;

  ahbl_sram_slave_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahbl_sram_slave #(.AW(10), .WAIT(2)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic xfer(input logic [31:0] addr, input logic [2:0] size, input logic wr,
                      input logic [31:0] wdata, output logic [31:0] rdata, output logic resp,
                      output int low, output logic first_resp);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = addr; bus.HSIZE = size; bus.HWRITE = wr;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = wdata;
    first_resp = bus.HRESP;
    low = 0;
    while (!bus.HREADYOUT && low < 20) begin
      low++;
      @(posedge HCLK); #1;
    end
    rdata = bus.HRDATA;
    resp  = bus.HRESP;
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset;
    bus.HSEL = 0; bus.HADDR = 0; bus.HTRANS = 0; bus.HSIZE = 0; bus.HWRITE = 0; bus.HWDATA = 0;
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    total++; if (bus.HREADYOUT !== 1'b1) begin bad++; $display("FAIL reset_hreadyout: got %b want 1", bus.HREADYOUT); end
    total++; if (bus.HRESP !== 1'b0) begin bad++; $display("FAIL reset_hresp: got %b want 0", bus.HRESP); end
    total++; if (bus.HRDATA !== 32'h0) begin bad++; $display("FAIL reset_hrdata: got %h want 0", bus.HRDATA); end
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
  endtask

  task automatic test_word;
    logic [31:0] rd; logic rs, fr; int low;
    xfer(32'h4, 3'd2, 1'b1, 32'hAABBCCDD, rd, rs, low, fr);
    total++; if (low !== EXP_WAIT) begin bad++; $display("FAIL word_wr_waits: got %0d want %0d", low, EXP_WAIT); end
    total++; if (rs !== 1'b0) begin bad++; $display("FAIL word_wr_resp: got %b want 0", rs); end
    xfer(32'h4, 3'd2, 1'b0, 32'h0, rd, rs, low, fr);
    total++; if (rd !== 32'hAABBCCDD) begin bad++; $display("FAIL word_rd_data: got %h want aabbccdd", rd); end
    total++; if (rs !== 1'b0) begin bad++; $display("FAIL word_rd_resp: got %b want 0", rs); end
    total++; if (low !== EXP_WAIT) begin bad++; $display("FAIL word_rd_waits: got %0d want %0d", low, EXP_WAIT); end
  endtask

  task automatic test_lanes;
    logic [31:0] rd; logic rs, fr; int low;
    xfer(32'h8, 3'd2, 1'b1, 32'h0, rd, rs, low, fr);
    xfer(32'h9, 3'd0, 1'b1, 32'hEEEE11EE, rd, rs, low, fr);
    total++; if (rs !== 1'b0) begin bad++; $display("FAIL byte_wr_resp: got %b want 0", rs); end
    xfer(32'hA, 3'd1, 1'b1, 32'h2233FFFF, rd, rs, low, fr);
    total++; if (rs !== 1'b0) begin bad++; $display("FAIL half_wr_resp: got %b want 0", rs); end
    xfer(32'h8, 3'd2, 1'b0, 32'h0, rd, rs, low, fr);
    total++; if (rd !== 32'h22331100) begin bad++; $display("FAIL lanes_rd_word: got %h want 22331100", rd); end
    xfer(32'hB, 3'd0, 1'b0, 32'h0, rd, rs, low, fr);
    total++; if (rd !== 32'h22331100) begin bad++; $display("FAIL lanes_rd_byte_full_word: got %h want 22331100", rd); end
  endtask

  task automatic test_error;
    logic [31:0] rd; logic rs, fr; int low;
    xfer(32'h0, 3'd2, 1'b1, 32'h0, rd, rs, low, fr);
    xfer(32'h1, 3'd2, 1'b1, 32'h55555555, rd, rs, low, fr);
    total++; if (low !== 1) begin bad++; $display("FAIL err_misaligned_len: got %0d want 1", low); end
    total++; if (fr !== 1'b1) begin bad++; $display("FAIL err1_hresp: got %b want 1", fr); end
    total++; if (rs !== 1'b1) begin bad++; $display("FAIL err2_hresp: got %b want 1", rs); end
    xfer(32'h0, 3'd3, 1'b1, 32'h66666666, rd, rs, low, fr);
    total++; if (low !== 1 || fr !== 1'b1 || rs !== 1'b1) begin bad++; $display("FAIL err_size3: got len=%0d r1=%b r2=%b want 1 1 1", low, fr, rs); end
    xfer(32'h1, 3'd1, 1'b1, 32'h77777777, rd, rs, low, fr);
    total++; if (low !== 1 || fr !== 1'b1 || rs !== 1'b1) begin bad++; $display("FAIL err_half_odd: got len=%0d r1=%b r2=%b want 1 1 1", low, fr, rs); end
    xfer(32'h0, 3'd2, 1'b0, 32'h0, rd, rs, low, fr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL err_mem_unchanged: got %h want 0", rd); end
    total++; if (rs !== 1'b0) begin bad++; $display("FAIL err_then_okay_resp: got %b want 0", rs); end
  endtask

  task automatic test_back_to_back;
    int n;
    bus.HSEL = 1; bus.HTRANS = 2'b10; bus.HADDR = 32'h10; bus.HSIZE = 3'd2; bus.HWRITE = 1;
    @(posedge HCLK); #1;
    bus.HWDATA = 32'h12345678;
    bus.HWRITE = 0;
    n = 0;
    while (!bus.HREADYOUT && n < 20) begin n++; @(posedge HCLK); #1; end
    total++; if (bus.HRDATA !== 32'h0) begin bad++; $display("FAIL b2b_wr_phase_hrdata: got %h want 0", bus.HRDATA); end
    @(posedge HCLK); #1;
    bus.HSEL = 0; bus.HTRANS = 2'b00;
    n = 0;
    while (!bus.HREADYOUT && n < 20) begin n++; @(posedge HCLK); #1; end
    total++; if (n !== EXP_WAIT) begin bad++; $display("FAIL b2b_rd_waits: got %0d want %0d", n, EXP_WAIT); end
    total++; if (bus.HRDATA !== 32'h12345678) begin bad++; $display("FAIL b2b_rd_data: got %h want 12345678", bus.HRDATA); end
    total++; if (bus.HRESP !== 1'b0) begin bad++; $display("FAIL b2b_rd_resp: got %b want 0", bus.HRESP); end
    @(posedge HCLK); #1;
  endtask

  task automatic test_idle;
    logic [31:0] rd; logic rs, fr; int low;
    bus.HSEL = 1; bus.HTRANS = 2'b00; bus.HADDR = 32'h4; bus.HSIZE = 3'd2; bus.HWRITE = 1;
    bus.HWDATA = 32'h99999999;
    repeat (2) begin
      @(posedge HCLK); #1;
      total++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin bad++; $display("FAIL idle_trans: got rdy=%b resp=%b want 1 0", bus.HREADYOUT, bus.HRESP); end
    end
    bus.HSEL = 0; bus.HTRANS = 2'b10;
    repeat (2) begin
      @(posedge HCLK); #1;
      total++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin bad++; $display("FAIL unselected: got rdy=%b resp=%b want 1 0", bus.HREADYOUT, bus.HRESP); end
    end
    bus.HTRANS = 2'b00;
    xfer(32'h4, 3'd2, 1'b0, 32'h0, rd, rs, low, fr);
    total++; if (rd !== 32'hAABBCCDD) begin bad++; $display("FAIL idle_mem_unchanged: got %h want aabbccdd", rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic rs, fr; int low;
    xfer(32'h20, 3'd2, 1'b1, 32'h0, rd, rs, low, fr);
    bus.HSEL = 1; bus.HTRANS = 2'b10; bus.HADDR = 32'h20; bus.HSIZE = 3'd2; bus.HWRITE = 1;
    @(posedge HCLK); #1;
    bus.HSEL = 0; bus.HTRANS = 2'b00; bus.HWDATA = 32'hDEADBEEF;
    #1 HRESETn = 1'b0;
    #1;
    total++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin bad++; $display("FAIL reset_mid_async: got rdy=%b resp=%b want 1 0", bus.HREADYOUT, bus.HRESP); end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    xfer(32'h20, 3'd2, 1'b0, 32'h0, rd, rs, low, fr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_mid_no_commit: got %h want 0", rd); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; logic rs, fr; int low;
    xfer(32'h0000_1000, 3'd2, 1'b1, 32'hCAFEF00D, rd, rs, low, fr);
    xfer(32'h0000_0000, 3'd2, 1'b0, 32'h0, rd, rs, low, fr);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL alias_low: got %h want cafef00d", rd); end
    xfer(32'h0000_0FFC, 3'd2, 1'b1, 32'h01020304, rd, rs, low, fr);
    xfer(32'hFFFF_FFFC, 3'd2, 1'b0, 32'h0, rd, rs, low, fr);
    total++; if (rd !== 32'h01020304) begin bad++; $display("FAIL alias_top_word: got %h want 01020304", rd); end
  endtask

  initial begin
    test_reset;
    test_word;
    test_lanes;
    test_error;
    test_back_to_back;
    test_idle;
    test_reset_mid;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahbl_sram_slave.md
# ahbl_sram_slave

AHB-Lite responder backed by a word-organised register-array memory. It is the slave-side counterpart of the bus master used in the SoC benches and sits on the AHB-Lite bus behind the address decoder as the RAM region. It supports byte, halfword and word transfers with byte-lane write enables, optional wait-state insertion, and a two-cycle ERROR response for illegal transfers.

## Interface
- AW, 10, word-address width; memory depth is 2^AW 32-bit words, 4 KB by default.
- WAIT, 1, wait states inserted per OKAY data phase when AHBL_SLV_WAIT_EN is defined; legal range 0-7.

- HCLK  input  1  bus clock; all state updates on its rising edge.
- HRESETn  input  1  reset, asynchronous and active-low.
- HSEL  input  1  slave select from the decoder.
- HADDR  input  32  byte address; bits [AW+1:2] select the word, bits above AW+1 are ignored (aliasing).
- HTRANS  input  2  transfer type; only HTRANS[1] is decoded (NONSEQ/SEQ = 1).
- HSIZE  input  3  0 = byte, 1 = halfword, 2 = word.
- HWRITE  input  1  1 = write.
- HWDATA  input  32  write data, valid in the data phase.
- HREADY  input  1  bus-level ready, which qualifies the address phase.
- HREADYOUT  output  1  slave ready.
- HRDATA  output  32  read data, a full word and not lane-masked.
- HRESP  output  1  0 = OKAY, 1 = ERROR.

## Operation
- Address phase is accepted when HSEL & HREADY & HTRANS[1] are high at a rising edge. On acceptance, the block registers the word address, HADDR[1:0], HSIZE and HWRITE.
- IDLE/BUSY transfers, or HSEL = 0, get a zero-wait OKAY response and cause no memory access.
- A transfer is illegal if any of these holds:
  - HSIZE > 2;
  - HSIZE = 2 with HADDR[1:0] != 0;
  - HSIZE = 1 with HADDR[0] = 1.
- Byte enables:
  - size 0: lane HADDR[1:0];
  - size 1: lanes {HADDR[1],0} and {HADDR[1],1};
  - size 2: all four lanes.
- Writes: enabled lanes of HWDATA are written at the edge that ends the data phase (HREADYOUT = 1). Other lanes are unchanged.
- Reads: HRDATA = mem[registered word address] combinationally during the read data phase, and 0 otherwise. The master extracts the lanes it needs.
- Back-to-back transfers are supported. A read whose address phase overlaps a write's data phase returns the newly written data.
- State machine:
  - IDLE: accept a legal transfer → WAIT_ST if the wait count > 0, else DATA. Accept an illegal transfer → ERR1.
  - WAIT_ST: HREADYOUT = 0, counter decrements; when it reaches 0 → DATA.
  - DATA: HREADYOUT = 1, HRESP = 0, access completes. A new accept follows the IDLE rules; otherwise → IDLE.
  - ERR1: HREADYOUT = 0, HRESP = 1 → ERR2.
  - ERR2: HREADYOUT = 1, HRESP = 1, no memory change. A new accept follows the IDLE rules; otherwise → IDLE.
- Memory contents are not cleared by reset.

## Timing
- Reset values: state IDLE, HREADYOUT = 1, HRESP = 0, HRDATA = 0, wait counter 0, registered address/control 0.
- OKAY latency is WAIT + 1 data-phase cycles with the macro, and 1 cycle without it.
- ERROR always takes exactly 2 cycles, with no wait states before ERR1.
- Acceptance of a new address phase is only possible on a cycle where HREADYOUT = 1 (HREADY is high).
- Reset asserted mid-transfer aborts the transfer:
  - a pending write is not committed;
  - outputs take their reset values asynchronously.
- At the word-address wrap (index 2^AW − 1 → 0), no special handling is applied; aliasing applies.

## Configuration
- AHBL_SLV_WAIT_EN defined: a 3-bit wait counter is loaded with WAIT on each legal accept, and the WAIT_ST state exists.
- AHBL_SLV_WAIT_EN undefined: no counter and no WAIT_ST; every OKAY transfer is zero-wait. The WAIT parameter is ignored.

## Test plan
- Word write 0xAABBCCDD to 0x0000_0004, then word read of 0x0000_0004 → HRDATA = 0xAABBCCDD, HRESP = 0. With AHBL_SLV_WAIT_EN and WAIT = 2, HREADYOUT is low for exactly 2 cycles on each transfer.
- Over word 0x8 = 0x00000000: byte write 0x11 to 0x9, then halfword write 0x2233 to 0xA, then word read 0x8 → 0x22331100.
- Word write to 0x0000_0001 → ERR1 (HREADYOUT = 0, HRESP = 1), then ERR2 (HREADYOUT = 1, HRESP = 1); word read of 0x0 is unchanged. Also HSIZE = 3 → ERROR.
- Back-to-back write 0x12345678 to 0x10 with an immediate read of 0x10 (address phase overlapping the write's data phase) → read returns 0x12345678.
- HTRANS = IDLE with HSEL = 1, and NONSEQ with HSEL = 0 → HREADYOUT stays 1, HRESP = 0, memory unchanged.
- Assert HRESETn low during the data phase of a write of 0xDEADBEEF to 0x20 (prior value 0) → HREADYOUT = 1, HRESP = 0 immediately; a later read of 0x20 returns 0.
